// File: rtl/cordic_control.sv
// Sequencing controller for an iterative CORDIC core: accepts one operand, steps the
// iteration counter, writes back x then y, and holds the result until it is consumed.
module cordic_control #(
    parameter int N = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8:1]           c,
    output logic [$clog2(N)-1:0] cnt,
    output logic                 busy
);

    localparam int W = $clog2(N);
    localparam logic [W-1:0] CntLast = W'(N - 1);
    localparam logic [W-1:0] CntPen  = W'(N - 2);

    typedef enum logic [2:0] {
        StIdle,
        StIter,
        StWrx,
        StWry,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        c         = '0;
        unique case (state_q)
            StIdle: begin
                busy     = 1'b0;
                // Gated by rst so the core sees no load strobe while held in reset.
                in_ready = rst;
                c[1]     = in_valid & rst;
                c[2]     = in_valid & rst;
                c[8]     = in_valid & rst;
                if (in_valid) begin
                    state_d = StIter;
                    cnt_d   = '0;
                end
            end
            StIter: begin
                c[2] = 1'b1;
                if (cnt_q == CntPen) begin
                    state_d = StWrx;
                    cnt_d   = CntLast;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            StWrx: begin
                c[6]    = 1'b1;
                state_d = StWry;
            end
            StWry: begin
                c[7]    = 1'b1;
                c[5]    = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign cnt = cnt_q;

endmodule

// File: tb/tb_cordic_control.sv
// Randomized bench for cordic_control at N=7 and N=2, checked against a cycle-age model.
module tb_cordic_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready7, out_valid7, busy7;
    logic [8:1] c7;
    logic [2:0] cnt7;
    logic       in_ready2, out_valid2, busy2;
    logic [8:1] c2;
    logic [0:0] cnt2;

    int n_chk = 0;
    int n_err = 0;

    // Cycles since the accepting edge; 0 means idle.
    int age7 = 0;
    int age2 = 0;

    always #5 clk = ~clk;

    cordic_control #(.N(7)) dut7 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready7),
        .out_valid (out_valid7),
        .out_ready (out_ready),
        .c         (c7),
        .cnt       (cnt7),
        .busy      (busy7)
    );

    cordic_control #(.N(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .c         (c2),
        .cnt       (cnt2),
        .busy      (busy2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_c(input int a, input int n, input logic iv, input logic r);
        if (a == 0)          return (iv && r) ? 8'b1000_0011 : 8'b0;
        else if (a <= n - 1) return 8'b0000_0010;
        else if (a == n)     return 8'b0010_0000;
        else if (a == n + 1) return 8'b0101_0000;
        else                 return 8'b0;
    endfunction

    function automatic int exp_cnt(input int a, input int n);
        if (a == 0)          return 0;
        else if (a <= n - 1) return a - 1;
        else                 return n - 1;
    endfunction

    function automatic int next_age(input int a, input int n, input logic iv, input logic ordy,
                                    input logic r);
        if (!r)              return 0;
        if (a == 0)          return iv ? 1 : 0;
        if (a <= n + 1)      return a + 1;
        return ordy ? 0 : a;
    endfunction

    task automatic check_all();
        check_eq("n7_c",         32'(c7),         32'(exp_c(age7, 7, in_valid, rst)));
        check_eq("n7_cnt",       32'(cnt7),       32'(exp_cnt(age7, 7)));
        check_eq("n7_in_ready",  32'(in_ready7),  32'(age7 == 0 && rst));
        check_eq("n7_out_valid", 32'(out_valid7), 32'(age7 >= 9));
        check_eq("n7_busy",      32'(busy7),      32'(age7 != 0));
        check_eq("n2_c",         32'(c2),         32'(exp_c(age2, 2, in_valid, rst)));
        check_eq("n2_cnt",       32'(cnt2),       32'(exp_cnt(age2, 2)));
        check_eq("n2_in_ready",  32'(in_ready2),  32'(age2 == 0 && rst));
        check_eq("n2_out_valid", 32'(out_valid2), 32'(age2 >= 4));
        check_eq("n2_busy",      32'(busy2),      32'(age2 != 0));
    endtask

    // Applies new inputs just after a rising edge, checks before the next one.
    task automatic step(input logic r, input logic iv, input logic ordy);
        @(posedge clk);
        age7 = next_age(age7, 7, in_valid, out_ready, rst);
        age2 = next_age(age2, 2, in_valid, out_ready, rst);
        #1;
        rst       = r;
        in_valid  = iv;
        out_ready = ordy;
        if (!r) begin
            age7 = 0;
            age2 = 0;
        end
        #3;
        check_all();
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #4;
        check_all();
        step(1'b0, 1'b1, 1'b0);

        // Single operation with backpressure in DONE, then release.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);

        // in_valid held high across whole operations.
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, (i % 4) == 3);

        // Reset in the middle of ITER, then a clean operation.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) < 4));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cordic_control.md
CORDIC_CONTROL -- requirements
Module: cordic_control

Interface
REQ-001 SHALL have parameter N, default 7, meaning the CORDIC iteration count; legal range N >= 2.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand on core data_w is valid.
REQ-005 SHALL have port in_ready  output  1  controller accepts an operand.
REQ-006 SHALL have port out_valid  output  1  core data_r holds a completed result.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-008 SHALL have port c  output  [8:1]  core control: c[1] load-select, c[2] l/r register enable, c[5] output-select (1 = r path), c[6] x-register enable, c[7] y-register enable, c[8] angle-register enable.
REQ-009 SHALL have port cnt  output  $clog2(N)  core iteration index / shift amount.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, ITER, WRX, WRY, DONE, with a registered state and a registered iteration counter.
REQ-012 SHALL drive c[3] and c[4] to 0 at all times.
REQ-013 IDLE: SHALL drive in_ready=1, out_valid=0, cnt=0, and c[1]=c[2]=c[8]=in_valid, all other c bits 0.
REQ-014 IDLE: on in_valid=1, SHALL transition to ITER with cnt=0; otherwise remain in IDLE.
REQ-015 ITER: SHALL drive c[2]=1, all other c bits 0, in_ready=0, and cnt equal to the iteration counter.
REQ-016 ITER: SHALL increment cnt each cycle; ITER SHALL last exactly N-1 cycles (cnt 0..N-2).
REQ-017 ITER: after the cnt=N-2 cycle, SHALL transition to WRX with cnt=N-1.
REQ-018 WRX: SHALL drive c[6]=1, c[5]=0, all other c bits 0, cnt=N-1, for one cycle, then transition to WRY.
REQ-019 WRY: SHALL drive c[7]=1, c[5]=1, all other c bits 0, cnt=N-1, for one cycle, then transition to DONE.
REQ-020 DONE: SHALL drive out_valid=1, c=0, in_ready=0, and hold cnt=N-1.
REQ-021 DONE: SHALL remain in DONE while out_ready=0; on out_ready=1 SHALL transition to IDLE with cnt=0.
REQ-022 An input handshake on edge 0 SHALL produce out_valid=1 from cycle N+2 onward: N-1 ITER cycles, then 1 WRX cycle, then 1 WRY cycle.
REQ-023 in_valid SHALL be ignored in every state other than IDLE; no operand SHALL be queued.
REQ-024 Simultaneous out_ready=1 and in_valid=1 in DONE SHALL NOT accept the new operand; it SHALL be accepted at the earliest in the following IDLE cycle.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 The counter SHALL never exceed N-1 and SHALL never wrap.

Reset
REQ-027 While rst=0, the controller SHALL asynchronously force IDLE, cnt=0, out_valid=0, and busy=0.
REQ-028 While rst=0, in_ready SHALL be 0 and c SHALL be 0; after release, IDLE rules (REQ-013) SHALL apply from the first cycle.
REQ-029 Reset asserted in any state, including mid-ITER, SHALL abort the operation, emit no out_valid, and require a new handshake after release.

Verification
REQ-030 With N=7, single operation: in_valid=1 for one cycle in IDLE -> c=8'b1000_0011 in that cycle; cnt=0..5 across cycles 1..6 with c[2]=1; cycle 7 c[6]=1, cnt=6; cycle 8 c[7]=1, c[5]=1; out_valid=1 from cycle 9.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, c=0, cnt=6; out_ready=1 -> IDLE next cycle.
REQ-032 Ignored inputs: in_valid held 1 throughout an operation -> exactly one ITER sequence; the second accept occurs in the first IDLE cycle after DONE.
REQ-033 Mid-operation reset: rst=0 at ITER cnt=3 -> immediately IDLE, cnt=0, c=0, no out_valid pulse; a new operation then completes normally.
REQ-034 With N=2 (cnt 1 bit): one ITER cycle with cnt=0, WRX/WRY with cnt=1, out_valid at cycle 4.
REQ-035 End-to-end: the controller drives cordic_core with B=14, N=7, x=0.5, y=0, angle=pi/4 -> data_r within 2 LSB of the golden model.
